// File: rtl/intr_ctrl_if.sv
// Bus between the interrupt sources / CPU and intr_ctrl.
// The master side drives requests and handshakes; the controller is the slave.
interface intr_ctrl_if #(
  parameter int NUM_SRC = 8,
  parameter int VEC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);

  logic [NUM_SRC-1:0] src;
  logic               trap;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               ack;
  logic               eoi;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic               irq;
  logic [VEC_W-1:0]   vector;
  logic               is_trap;

  modport master (
    output src, trap, mask_we, mask_wdata, ack, eoi,
    input  mask, pending, irq, vector, is_trap
  );

  modport slave (
    input  src, trap, mask_we, mask_wdata, ack, eoi,
    output mask, pending, irq, vector, is_trap
  );

endinterface

// File: rtl/intr_ctrl.sv
// Interrupt/trap controller: latches requests, masks, arbitrates and handshakes with the CPU.
// Define INTR_CTRL_SYNC_EN to add a 2-flop synchroniser on src and trap.
module intr_ctrl #(
  parameter int                 NUM_SRC   = 8,
  parameter int                 VEC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = NUM_SRC'(8'h0F)
) (
  input logic         clk,
  input logic         reset_n,
  intr_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_q;
  logic               irq_q;
  logic [VEC_W-1:0]   vector_q;
  logic               isTrap_q;

  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               trapPend_q, trapPend_d;

  logic [NUM_SRC-1:0] srcIn;
  logic               trapIn;
  logic [NUM_SRC-1:0] srcSamp_q, srcPrev_q;
  logic               trapSamp_q, trapPrev_q;

  logic [NUM_SRC-1:0] srcRise;
  logic               trapRise;
  logic               ackTake;
  logic [NUM_SRC-1:0] cand;
  logic               anyReq;
  logic [VEC_W-1:0]   winIdx;

`ifdef INTR_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] srcMeta_q, srcSync_q;
  logic               trapMeta_q, trapSync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srcMeta_q  <= '0;
      srcSync_q  <= '0;
      trapMeta_q <= 1'b0;
      trapSync_q <= 1'b0;
    end else begin
      srcMeta_q  <= bus.src;
      srcSync_q  <= srcMeta_q;
      trapMeta_q <= bus.trap;
      trapSync_q <= trapMeta_q;
    end
  end

  assign srcIn  = srcSync_q;
  assign trapIn = trapSync_q;
`else
  assign srcIn  = bus.src;
  assign trapIn = bus.trap;
`endif

  // One sample stage plus history: edges are detected between consecutive samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srcSamp_q  <= '0;
      srcPrev_q  <= '0;
      trapSamp_q <= 1'b0;
      trapPrev_q <= 1'b0;
    end else begin
      srcSamp_q  <= srcIn;
      srcPrev_q  <= srcSamp_q;
      trapSamp_q <= trapIn;
      trapPrev_q <= trapSamp_q;
    end
  end

  assign srcRise  = srcSamp_q & ~srcPrev_q;
  assign trapRise = trapSamp_q & ~trapPrev_q;
  assign ackTake  = (state_q == REQ) && bus.ack;

  // A new edge in the same cycle as the ack-clear wins, so no event is lost.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      pending_d[i] = EDGE_MASK[i]
                   ? (srcRise[i] |
                      (pending_q[i] & ~(ackTake & ~isTrap_q & (vector_q == VEC_W'(i)))))
                   : srcSamp_q[i];
    end
    trapPend_d = trapRise | (trapPend_q & ~(ackTake & isTrap_q));
  end

  always_comb begin
    cand   = pending_q & ~mask_q;
    anyReq = trapPend_q | (|cand);
    winIdx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) winIdx = VEC_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      trapPend_q <= 1'b0;
      mask_q     <= '1;
    end else begin
      pending_q  <= pending_d;
      trapPend_q <= trapPend_d;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
    end
  end

  // The grant is frozen from IDLE until the CPU acks, whatever arrives meanwhile.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      vector_q <= '0;
      isTrap_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            state_q <= REQ;
            irq_q   <= 1'b1;
            if (trapPend_q) begin
              isTrap_q <= 1'b1;
              vector_q <= '0;
            end else begin
              isTrap_q <= 1'b0;
              vector_q <= winIdx;
            end
          end
        end
        REQ: begin
          if (bus.ack) begin
            state_q <= SERVICE;
            irq_q   <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.eoi) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mask    = mask_q;
  assign bus.pending = pending_q;
  assign bus.irq     = irq_q;
  assign bus.vector  = vector_q;
  assign bus.is_trap = isTrap_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl (NUM_SRC=8, EDGE_MASK=8'h0F).
// Expected latencies shift by 2 cycles when INTR_CTRL_SYNC_EN is defined.
module tb_intr_ctrl;

`ifdef INTR_CTRL_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   passes;

  intr_ctrl_if #(.NUM_SRC(8), .VEC_W(3)) bus ();

  intr_ctrl #(.NUM_SRC(8), .VEC_W(3), .EDGE_MASK(8'h0F)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs, then return 1ns after the clock edge.
  task automatic applyStimulus(input logic [7:0] s, input logic t, input logic mwe,
                               input logic [7:0] mw, input logic a, input logic e);
    bus.src        = s;
    bus.trap       = t;
    bus.mask_we    = mwe;
    bus.mask_wdata = mw;
    bus.ack        = a;
    bus.eoi        = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset_n = 1'b0;
    bus.src = '0; bus.trap = 1'b0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.ack = 1'b0; bus.eoi = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    checkOutput("rst_irq",     32'(bus.irq),     32'h0);
    checkOutput("rst_pending", 32'(bus.pending), 32'h00);
    checkOutput("rst_mask",    32'(bus.mask),    32'hFF);
    checkOutput("rst_vector",  32'(bus.vector),  32'h0);
    checkOutput("rst_is_trap", 32'(bus.is_trap), 32'h0);

    // Scenario 1: single edge source through the full handshake
    applyStimulus(8'h00, 0, 1, 8'h00, 0, 0);
    checkOutput("s1_mask", 32'(bus.mask), 32'h00);
    applyStimulus(8'h04, 0, 0, 8'h00, 0, 0);
    idle(EXTRA);
    checkOutput("s1_pend_early", 32'(bus.pending), 32'h00);
    idle(1);
    checkOutput("s1_pending", 32'(bus.pending), 32'h04);
    checkOutput("s1_irq_early", 32'(bus.irq), 32'h0);
    idle(1);
    checkOutput("s1_irq", 32'(bus.irq), 32'h1);
    checkOutput("s1_vector", 32'(bus.vector), 32'h2);
    applyStimulus(8'h00, 0, 0, 8'h00, 1, 0);
    checkOutput("s1_ack_irq", 32'(bus.irq), 32'h0);
    checkOutput("s1_ack_pend", 32'(bus.pending), 32'h00);
    applyStimulus(8'h00, 0, 0, 8'h00, 0, 1);
    idle(2);
    checkOutput("s1_done_irq", 32'(bus.irq), 32'h0);

    // Scenario 2: src[1] masked, src[5] (level) wins; then unmask src[1]
    applyStimulus(8'h00, 0, 1, 8'h02, 0, 0);
    applyStimulus(8'h22, 0, 0, 8'h00, 0, 0);
    for (int k = 0; k < EXTRA + 2; k++) applyStimulus(8'h20, 0, 0, 8'h00, 0, 0);
    checkOutput("s2_irq", 32'(bus.irq), 32'h1);
    checkOutput("s2_vector", 32'(bus.vector), 32'h5);
    for (int k = 0; k < EXTRA; k++) applyStimulus(8'h00, 0, 0, 8'h00, 0, 0);
    applyStimulus(8'h00, 0, 0, 8'h00, 1, 0);
    checkOutput("s2_ack_irq", 32'(bus.irq), 32'h0);
    idle(1);
    checkOutput("s2_pend_masked", 32'(bus.pending), 32'h02);
    applyStimulus(8'h00, 0, 0, 8'h00, 0, 1);
    applyStimulus(8'h00, 0, 1, 8'h00, 0, 0);
    checkOutput("s2_old_mask_irq", 32'(bus.irq), 32'h0);
    idle(1);
    checkOutput("s2_irq1", 32'(bus.irq), 32'h1);
    checkOutput("s2_vector1", 32'(bus.vector), 32'h1);
    applyStimulus(8'h00, 0, 0, 8'h00, 1, 0);
    applyStimulus(8'h00, 0, 0, 8'h00, 0, 1);
    idle(1);

    // Scenario 3: level src[6] held through eoi re-requests; dropped, it does not
    for (int k = 0; k < EXTRA + 3; k++) applyStimulus(8'h40, 0, 0, 8'h00, 0, 0);
    checkOutput("s3_irq", 32'(bus.irq), 32'h1);
    checkOutput("s3_vector", 32'(bus.vector), 32'h6);
    applyStimulus(8'h40, 0, 0, 8'h00, 1, 0);
    checkOutput("s3_ack_irq", 32'(bus.irq), 32'h0);
    checkOutput("s3_level_kept", 32'(bus.pending), 32'h40);
    applyStimulus(8'h40, 0, 0, 8'h00, 0, 1);
    checkOutput("s3_eoi_irq", 32'(bus.irq), 32'h0);
    applyStimulus(8'h40, 0, 0, 8'h00, 0, 0);
    checkOutput("s3_rereq_irq", 32'(bus.irq), 32'h1);
    checkOutput("s3_rereq_vec", 32'(bus.vector), 32'h6);
    applyStimulus(8'h40, 0, 0, 8'h00, 1, 0);
    idle(EXTRA + 2);
    checkOutput("s3_drop_pend", 32'(bus.pending), 32'h00);
    applyStimulus(8'h00, 0, 0, 8'h00, 0, 1);
    idle(2);
    checkOutput("s3_no_rereq", 32'(bus.irq), 32'h0);

    // Scenario 4: trap during REQ does not re-arbitrate, served after eoi with all masked
    applyStimulus(8'h08, 0, 0, 8'h00, 0, 0);
    idle(EXTRA + 2);
    checkOutput("s4_vector3", 32'(bus.vector), 32'h3);
    applyStimulus(8'h00, 1, 0, 8'h00, 0, 0);
    idle(EXTRA + 2);
    checkOutput("s4_held_vec", 32'(bus.vector), 32'h3);
    checkOutput("s4_held_trap", 32'(bus.is_trap), 32'h0);
    checkOutput("s4_held_irq", 32'(bus.irq), 32'h1);
    applyStimulus(8'h00, 0, 1, 8'hFF, 0, 0);
    applyStimulus(8'h00, 0, 0, 8'h00, 1, 0);
    checkOutput("s4_ack_pend", 32'(bus.pending), 32'h00);
    applyStimulus(8'h00, 0, 0, 8'h00, 0, 1);
    idle(1);
    checkOutput("s4_trap_irq", 32'(bus.irq), 32'h1);
    checkOutput("s4_trap_flag", 32'(bus.is_trap), 32'h1);
    checkOutput("s4_trap_vec", 32'(bus.vector), 32'h0);
    checkOutput("s4_trap_mask", 32'(bus.mask), 32'hFF);
    applyStimulus(8'h00, 0, 0, 8'h00, 1, 0);
    applyStimulus(8'h00, 0, 0, 8'h00, 0, 1);
    idle(2);
    checkOutput("s4_trap_once", 32'(bus.irq), 32'h0);

    // Edge arriving in the same cycle as its ack-clear is kept
    applyStimulus(8'h00, 0, 1, 8'h00, 0, 0);
    applyStimulus(8'h01, 0, 0, 8'h00, 0, 0);
    applyStimulus(8'h00, 0, 0, 8'h00, 0, 0);
    applyStimulus(8'h01, 0, 0, 8'h00, 0, 0);
    idle(EXTRA);
    applyStimulus(8'h00, 0, 0, 8'h00, 1, 0);
    checkOutput("set_wins_pend", 32'(bus.pending), 32'h01);
    checkOutput("set_wins_irq", 32'(bus.irq), 32'h0);
    applyStimulus(8'h00, 0, 0, 8'h00, 0, 1);
    idle(1);
    checkOutput("set_wins_regrant", 32'(bus.irq), 32'h1);
    checkOutput("set_wins_vec", 32'(bus.vector), 32'h0);
    applyStimulus(8'h00, 0, 0, 8'h00, 1, 0);
    applyStimulus(8'h00, 0, 0, 8'h00, 0, 1);
    idle(1);

    // Scenario 5: async reset while in SERVICE
    applyStimulus(8'h03, 0, 0, 8'h00, 0, 0);
    idle(EXTRA + 2);
    applyStimulus(8'h00, 0, 0, 8'h00, 1, 0);
    checkOutput("s5_pre_pend", 32'(bus.pending), 32'h02);
    reset_n = 1'b0;
    #1;
    checkOutput("s5_rst_irq", 32'(bus.irq), 32'h0);
    checkOutput("s5_rst_pend", 32'(bus.pending), 32'h00);
    checkOutput("s5_rst_trap", 32'(bus.is_trap), 32'h0);
    checkOutput("s5_rst_mask", 32'(bus.mask), 32'hFF);
    @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(8'h00, 0, 0, 8'h00, 0, 1);
    applyStimulus(8'h00, 0, 0, 8'h00, 1, 0);
    idle(1);
    checkOutput("s5_stray_irq", 32'(bus.irq), 32'h0);
    applyStimulus(8'h00, 0, 1, 8'h00, 0, 0);
    applyStimulus(8'h10, 0, 0, 8'h00, 0, 0);
    for (int k = 0; k < EXTRA + 2; k++) applyStimulus(8'h10, 0, 0, 8'h00, 0, 0);
    checkOutput("s5_after_irq", 32'(bus.irq), 32'h1);
    checkOutput("s5_after_vec", 32'(bus.vector), 32'h4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
